ddr_read_channel: RTL and testbench

Per-channel read client sitting directly downstream of the DDR3 DMA engine's shared read port. It accepts a long read command (start address + length in 512-bit beats), splits it into bursts of at most MAX_BURST beats, drives one `read_req_N` slot of the engine, captures the beats tagged for its channel from the shared `dout` bus into a local FIFO, and presents them to the consumer with valid/ready back-pressure. The engine has no read back-pressure (`dout_rdy` is tied high), so this block issues a burst only when FIFO space for the whole burst is guaranteed.

---
 rtl/ddr_read_channel.sv | 164 ++++++++++++++++
 tb/tb_ddr_read_channel.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_read_channel.sv
// Per-channel read client for the DDR3 DMA engine: splits a long read into bursts,
// issues them only when the local FIFO can absorb a whole burst, and buffers the returned beats.
module ddr_read_channel #(
  parameter int CH_ID     = 0,
  parameter int DEPTH     = 32,
  parameter int MAX_BURST = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [26:0]  cmd_addr,
  input  logic [26:0]  cmd_len,
  output logic         cmd_done,
  output logic         read_req,
  output logic [26:0]  read_start_addr,
  output logic [26:0]  read_length,
  input  logic         read_ack,
  input  logic [511:0] dout,
  input  logic [15:0]  dout_en,
  input  logic         dout_eop,
  output logic [511:0] rd_data,
  output logic         rd_valid,
  output logic         rd_last,
  input  logic         rd_ready,
  output logic         err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // SKIP gives a zero-length command the same two-cycle turnaround as a real one.
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_DATA, S_SKIP, S_FIN} state_t;

  state_t        state, state_nxt;
  logic [26:0]   addr, remain, burst_len, beat_cnt;
  logic [26:0]   chunk, cmd_chunk;
  logic          req_q, req_d;
  logic          err_q, err_set;
  logic          load_cmd, take_ack;
  logic [CW-1:0] fifo_cnt, cnt_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [512:0]  mem [DEPTH];
  logic [512:0]  head;
  logic          own, push, pop, full;

  // Handshakes: cmd is accepted on an edge with cmd_valid && cmd_ready; a beat is
  // popped on an edge with rd_valid && rd_ready; a request completes on an edge with
  // read_req && read_ack, and read_req/address/length hold stable until then.

  assign own       = dout_en[CH_ID];
  assign full      = (fifo_cnt == CW'(DEPTH));
  assign rd_valid  = (fifo_cnt != '0);
  assign pop       = rd_valid && rd_ready;
  assign push      = own && (state == S_DATA) && !full;
  assign cnt_nxt   = fifo_cnt + CW'(push) - CW'(pop);
  assign chunk     = (remain > 27'(MAX_BURST)) ? 27'(MAX_BURST) : remain;
  assign cmd_chunk = (cmd_len > 27'(MAX_BURST)) ? 27'(MAX_BURST) : cmd_len;

  function automatic logic fits(input logic [CW-1:0] cnt, input logic [26:0] len);
    return ({{(28-CW){1'b0}}, cnt} + {1'b0, len}) <= 28'(DEPTH);
  endfunction

  always_comb begin
    state_nxt = state;
    req_d     = 1'b0;
    err_set   = own && (state != S_DATA);
    load_cmd  = 1'b0;
    take_ack  = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          load_cmd = 1'b1;
          if (cmd_len == '0) begin
            state_nxt = S_SKIP;
          end else begin
            state_nxt = S_REQ;
            req_d     = fits(cnt_nxt, cmd_chunk);
          end
        end
      end
      S_REQ: begin
        if (req_q && read_ack) begin
          take_ack  = 1'b1;
          state_nxt = S_DATA;
        end else if (req_q) begin
          req_d = 1'b1;
        end else begin
          req_d = fits(cnt_nxt, chunk);
        end
      end
      S_DATA: begin
        if (own && full) err_set = 1'b1;
        if (own && dout_eop) begin
          if (beat_cnt + 27'd1 != burst_len) err_set = 1'b1;
          if (remain != '0) begin
            state_nxt = S_REQ;
            req_d     = fits(cnt_nxt, chunk);
          end else begin
            state_nxt = S_FIN;
          end
        end
      end
      S_SKIP:  state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      req_q     <= 1'b0;
      err_q     <= 1'b0;
      addr      <= '0;
      remain    <= '0;
      burst_len <= '0;
      beat_cnt  <= '0;
    end else begin
      state <= state_nxt;
      req_q <= req_d;
      if (err_set) err_q <= 1'b1;
      if (load_cmd) begin
        addr   <= cmd_addr;
        remain <= cmd_len;
      end else if (take_ack) begin
        addr      <= addr + chunk;
        remain    <= remain - chunk;
        burst_len <= chunk;
        beat_cnt  <= '0;
      end else if (own && state == S_DATA) begin
        beat_cnt <= beat_cnt + 27'd1;
      end
    end
  end

  // remain already excludes the current burst, so zero marks the command's final burst.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {dout_eop && (remain == '0), dout};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_cnt <= cnt_nxt;
    end
  end

  assign head            = mem[rd_ptr];
  assign rd_data         = rd_valid ? head[511:0] : '0;
  assign rd_last         = rd_valid && head[512];
  assign cmd_ready       = (state == S_IDLE);
  assign cmd_done        = (state == S_FIN);
  assign read_req        = req_q;
  assign read_start_addr = addr;
  assign read_length     = chunk;
  assign err             = err_q;

endmodule

// File: tb/tb_ddr_read_channel.sv
// Directed bench for ddr_read_channel: the bench plays the DMA engine and checks the
// consumer stream through an expected-beat queue popped by an independent monitor.
module tb_ddr_read_channel;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [26:0]  cmd_addr;
  logic [26:0]  cmd_len;
  logic         cmd_done;
  logic         read_req;
  logic [26:0]  read_start_addr;
  logic [26:0]  read_length;
  logic         read_ack;
  logic [511:0] dout;
  logic [15:0]  dout_en;
  logic         dout_eop;
  logic [511:0] rd_data;
  logic         rd_valid;
  logic         rd_last;
  logic         rd_ready;
  logic         err;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int pop_cnt  = 0;
  logic [512:0] exp_q[$];

  ddr_read_channel #(.CH_ID(3), .DEPTH(32), .MAX_BURST(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_done(cmd_done),
    .read_req(read_req), .read_start_addr(read_start_addr), .read_length(read_length),
    .read_ack(read_ack),
    .dout(dout), .dout_en(dout_en), .dout_eop(dout_eop),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
    .err(err)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [512:0] e;
    if (cmd_done) done_cnt++;
    if (!rst && rd_valid && rd_ready) begin
      pop_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected actual=%h last=%b required=no beat", rd_data[31:0], rd_last);
      end else begin
        e = exp_q.pop_front();
        if ({rd_last, rd_data} !== e) begin
          failures++;
          $display("FAIL rd_beat actual=%h last=%b required=%h last=%b",
                   rd_data[31:0], rd_last, e[31:0], e[512]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] mk_data(input logic [26:0] a);
    return {16{a, 5'h15}};
  endfunction

  // driver tasks: all start and end just after a rising edge
  task automatic drive_beat(input int ch, input logic [511:0] d, input logic eop);
    dout_en  = 16'(1) << ch;
    dout     = d;
    dout_eop = eop;
    @(posedge clk); #1;
    dout_en  = '0;
    dout     = '0;
    dout_eop = 1'b0;
  endtask

  task automatic send_cmd(input logic [26:0] a, input logic [26:0] n);
    int w = 0;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = n;
    @(negedge clk);
    while (!cmd_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      failures++;
      $display("FAIL cmd_accept_timeout actual=0 required=1");
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_req(output int w);
    w = 0;
    @(negedge clk);
    while (!read_req && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!read_req) begin
      failures++;
      $display("FAIL read_req_timeout actual=0 required=1");
      w = -1;
    end
  endtask

  // n: expected burst length, n_drive: own beats driven, eop_at: beat carrying eop (1-based)
  task automatic serve_burst(input logic [26:0] a, input int n, input int n_drive,
                             input int eop_at, input bit final_b, input bit mix);
    int w;
    logic [511:0] d;
    logic eop;
    wait_req(w);
    if (w < 0) return;
    chk("req_addr", 32'(read_start_addr), 32'(a));
    chk("req_len", 32'(read_length), 32'(n));
    @(posedge clk); #1;
    read_ack = 1'b1;
    @(posedge clk); #1;
    read_ack = 1'b0;
    @(negedge clk);
    chk("req_drop", 32'(read_req), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < n_drive; i++) begin
      if (mix) drive_beat((i % 2 == 0) ? 5 : 2, mk_data(~(a + 27'(i))), i == 2);
      d   = mk_data(a + 27'(i));
      eop = (i == eop_at - 1);
      exp_q.push_back({eop && final_b, d});
      drive_beat(3, d, eop);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_valid", 32'(rd_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  // main sequence
  initial begin
    int d0, p0, hi;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; read_ack = 1'b0;
    dout = '0; dout_en = '0; dout_eop = 1'b0; rd_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_read_req", 32'(read_req), 32'd0);
    chk("rst_addr", 32'(read_start_addr), 32'd0);
    chk("rst_len", 32'(read_length), 32'd0);
    chk("rst_out", {28'd0, cmd_done, rd_valid, rd_last, err}, 32'd0);
    chk("rst_rd_data", rd_data[31:0], 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 40 beats in three bursts
    d0 = done_cnt;
    send_cmd(27'h100, 27'd40);
    @(negedge clk);
    chk("accept_to_req", 32'(read_req), 32'd1);
    serve_burst(27'h100, 16, 16, 16, 1'b0, 1'b0);
    serve_burst(27'h110, 16, 16, 16, 1'b0, 1'b0);
    serve_burst(27'h120, 8, 8, 8, 1'b1, 1'b0);
    drain();
    chk("t1_done", 32'(done_cnt - d0), 32'd1);
    chk("t1_err", 32'(err), 32'd0);

    // back-pressure: FIFO full after two bursts, third waits for 16 pops
    rd_ready = 1'b0;
    d0 = done_cnt;
    send_cmd(27'h100, 27'd64);
    serve_burst(27'h100, 16, 16, 16, 1'b0, 1'b0);
    serve_burst(27'h110, 16, 16, 16, 1'b0, 1'b0);
    hi = 0;
    repeat (10) begin
      @(negedge clk);
      if (read_req) hi++;
    end
    chk("bp_hold_full", 32'(hi), 32'd0);
    chk("bp_full_valid", 32'(rd_valid), 32'd1);
    @(posedge clk); #1;
    p0 = pop_cnt;
    rd_ready = 1'b1;
    repeat (15) @(posedge clk);
    #1 rd_ready = 1'b0;
    hi = 0;
    repeat (5) begin
      @(negedge clk);
      if (read_req) hi++;
    end
    chk("bp_hold_15pops", 32'(hi), 32'd0);
    chk("bp_pop15", 32'(pop_cnt - p0), 32'd15);
    @(posedge clk); #1;
    rd_ready = 1'b1;
    @(posedge clk); #1;
    rd_ready = 1'b0;
    @(negedge clk);
    chk("bp_release", 32'(read_req), 32'd1);
    chk("bp_release_addr", 32'(read_start_addr), 32'h120);
    @(posedge clk); #1;
    rd_ready = 1'b1;
    serve_burst(27'h120, 16, 16, 16, 1'b0, 1'b0);
    serve_burst(27'h130, 16, 16, 16, 1'b1, 1'b0);
    drain();
    chk("t2_done", 32'(done_cnt - d0), 32'd1);

    // foreign channel beats interleaved
    p0 = pop_cnt;
    send_cmd(27'h300, 27'd8);
    serve_burst(27'h300, 8, 8, 8, 1'b1, 1'b1);
    drain();
    chk("mix_count", 32'(pop_cnt - p0), 32'd8);
    chk("mix_err", 32'(err), 32'd0);

    // zero-length command
    d0 = done_cnt;
    send_cmd(27'h600, 27'd0);
    @(negedge clk);
    chk("z_c1", {29'd0, cmd_ready, cmd_done, read_req}, 32'b000);
    @(negedge clk);
    chk("z_c2", {29'd0, cmd_ready, cmd_done, read_req}, 32'b010);
    @(negedge clk);
    chk("z_c3", {29'd0, cmd_ready, cmd_done, read_req}, 32'b100);
    chk("z_done", 32'(done_cnt - d0), 32'd1);
    chk("z_fifo", 32'(rd_valid), 32'd0);
    @(posedge clk); #1;

    // early eop in a 16-beat burst
    d0 = done_cnt;
    p0 = pop_cnt;
    send_cmd(27'h200, 27'd32);
    serve_burst(27'h200, 16, 5, 5, 1'b0, 1'b0);
    @(negedge clk);
    chk("eop_err", 32'(err), 32'd1);
    serve_burst(27'h210, 16, 16, 16, 1'b1, 1'b0);
    drain();
    chk("eop_beats", 32'(pop_cnt - p0), 32'd21);
    chk("eop_done", 32'(done_cnt - d0), 32'd1);

    // reset in the middle of a burst with 7 beats buffered
    rd_ready = 1'b0;
    send_cmd(27'h400, 27'd16);
    serve_burst(27'h400, 16, 7, 16, 1'b1, 1'b0);
    @(negedge clk);
    chk("pre_rst_valid", 32'(rd_valid), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_out", {27'd0, rd_valid, read_req, err, cmd_ready, rd_last}, 32'b00010);
    chk("mid_rst_data", rd_data[31:0], 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    rd_ready = 1'b1;
    d0 = done_cnt;
    send_cmd(27'h500, 27'd8);
    serve_burst(27'h500, 8, 8, 8, 1'b1, 1'b0);
    drain();
    chk("post_rst_done", 32'(done_cnt - d0), 32'd1);
    chk("post_rst_err", 32'(err), 32'd0);

    // stray owned beat while idle
    drive_beat(3, mk_data(27'h7ff), 1'b1);
    @(negedge clk);
    chk("stray_err", 32'(err), 32'd1);
    chk("stray_dropped", 32'(rd_valid), 32'd0);
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
